rtc_access_sequencer: RTL and testbench

RTC_ACCESS_SEQUENCER -- requirements
Module: rtc_access_sequencer

---
 rtl/rtc_access_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_rtc_access_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_access_sequencer.sv
// rtc_access_sequencer: arbitrates user register writes and periodic read refreshes
// of the RTC channels onto a write engine and a read engine. One transaction at a time,
// writes outrank a pending refresh, all outputs registered.
// Optional watchdog on the wait states: define RTC_SEQ_TIMEOUT_EN.
module rtc_access_sequencer #(
  parameter int                NUM_CH      = 2,
  parameter int                NUM_REGS    = 3,
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h21,
  parameter logic [ADDR_W-1:0] CH_STRIDE   = 'h20,
  parameter int                ALARM_CH    = 1,
  parameter int                REFRESH_DIV = 1000,
  parameter int                TIMEOUT     = 4096,
  localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_req,
  input  logic [CH_W-1:0]            wr_ch,
  input  logic [NUM_REGS*DATA_W-1:0] wr_data,
  input  logic                       init_busy,
  input  logic                       wr_done,
  input  logic                       rd_done,
  input  logic [NUM_REGS*DATA_W-1:0] rd_data,
  output logic                       wr_start,
  output logic                       rd_start,
  output logic [NUM_REGS*ADDR_W-1:0] addr_bus,
  output logic [NUM_REGS*DATA_W-1:0] data_bus,
  output logic [CH_W-1:0]            cur_ch,
  output logic                       alarm_on,
  output logic                       busy,
  output logic                       wr_ack,
  output logic                       wr_err,
  output logic                       rd_valid,
  output logic [CH_W-1:0]            rd_ch,
  output logic [NUM_REGS*DATA_W-1:0] snapshot,
  output logic                       timeout_err
);

  localparam int REF_W = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE = 2'd0, WR_WAIT = 2'd1, RD_WAIT = 2'd2} state_t;

  state_t                     state, state_d;
  logic [REF_W-1:0]           ref_cnt;
  logic                       ref_wrap;
  logic                       tick;
  logic [CH_W-1:0]            rd_ptr;
  logic                       wr_ok, wr_bad, rd_go, wr_fin, rd_fin, to_hit;
  logic [CH_W-1:0]            cur_ch_d, rd_ch_d, rd_ptr_d;
  logic [NUM_REGS*ADDR_W-1:0] addr_d;
  logic [NUM_REGS*DATA_W-1:0] data_d, snap_d;
  logic                       busy_d, alarm_d;

  // Register i of channel ch lives at BASE_ADDR + ch*CH_STRIDE + i; the
  // arithmetic is done at ADDR_W bits so it wraps naturally.
  function automatic logic [NUM_REGS*ADDR_W-1:0] addr_of(input logic [CH_W-1:0] ch);
    logic [NUM_REGS*ADDR_W-1:0] a;
    a = '0;
    for (int i = 0; i < NUM_REGS; i++)
      a[i*ADDR_W +: ADDR_W] = BASE_ADDR + ADDR_W'(ch) * CH_STRIDE + ADDR_W'(i);
    return a;
  endfunction

  assign ref_wrap = (ref_cnt == REF_W'(REFRESH_DIV - 1));

  // Free-running refresh divider; each wrap leaves a tick pending until a read is issued
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      tick    <= (tick & ~rd_go) | ref_wrap;
    end
  end

  // Start/finish qualification: only IDLE launches work, and a write beats the refresh
  always_comb begin
    wr_ok  = 1'b0;
    wr_bad = 1'b0;
    rd_go  = 1'b0;
    if (state == IDLE && !init_busy) begin
      if (wr_req) begin
        if (int'(wr_ch) < NUM_CH) wr_ok  = 1'b1;
        else                      wr_bad = 1'b1;
      end else begin
        rd_go = tick;
      end
    end
    wr_fin = (state == WR_WAIT) && wr_done;
    rd_fin = (state == RD_WAIT) && rd_done;
  end

`ifdef RTC_SEQ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] wd_cnt;

  // A completion in the final cycle still counts as a normal finish
  assign to_hit = (state != IDLE) && !wr_fin && !rd_fin && (wd_cnt == WD_W'(TIMEOUT - 1));

  // Cycles spent in the current wait state; restarts from zero on every entry
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) wd_cnt <= '0;
    else                        wd_cnt <= wd_cnt + 1'b1;
  end

  // Sticky watchdog flag, only reset clears it
  always_ff @(posedge clk) begin
    if (reset)       timeout_err <= 1'b0;
    else if (to_hit) timeout_err <= 1'b1;
  end
`else
  assign to_hit = 1'b0;
  // No watchdog built; TIMEOUT is a positive count so this is constant low
  assign timeout_err = (TIMEOUT < 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (wr_ok) state_d = WR_WAIT;
               else if (rd_go) state_d = RD_WAIT;
      WR_WAIT: if (wr_fin || to_hit) state_d = IDLE;
      RD_WAIT: if (rd_fin || to_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; bus contents only change at a start
  always_comb begin
    cur_ch_d = cur_ch;
    addr_d   = addr_bus;
    data_d   = data_bus;
    snap_d   = snapshot;
    rd_ch_d  = rd_ch;
    rd_ptr_d = rd_ptr;
    if (wr_ok) begin
      cur_ch_d = wr_ch;
      addr_d   = addr_of(wr_ch);
      data_d   = wr_data;
    end else if (rd_go) begin
      cur_ch_d = rd_ptr;
      addr_d   = addr_of(rd_ptr);
    end
    if (rd_fin) begin
      snap_d  = rd_data;
      rd_ch_d = cur_ch;
    end
    // A timed-out read still moves on so one dead channel cannot starve the rest
    if ((state == RD_WAIT) && (rd_fin || to_hit))
      rd_ptr_d = (rd_ptr == CH_W'(NUM_CH - 1)) ? '0 : rd_ptr + 1'b1;
    busy_d  = (state_d != IDLE);
    alarm_d = (state_d == WR_WAIT) && (int'(cur_ch_d) == ALARM_CH);
  end

  // Output and bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_start <= 1'b0;
      rd_start <= 1'b0;
      wr_ack   <= 1'b0;
      wr_err   <= 1'b0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      alarm_on <= 1'b0;
      cur_ch   <= '0;
      rd_ch    <= '0;
      rd_ptr   <= '0;
      addr_bus <= '0;
      data_bus <= '0;
      snapshot <= '0;
    end else begin
      wr_start <= wr_ok;
      rd_start <= rd_go;
      wr_ack   <= wr_fin;
      wr_err   <= wr_bad;
      rd_valid <= rd_fin;
      busy     <= busy_d;
      alarm_on <= alarm_d;
      cur_ch   <= cur_ch_d;
      rd_ch    <= rd_ch_d;
      rd_ptr   <= rd_ptr_d;
      addr_bus <= addr_d;
      data_bus <= data_d;
      snapshot <= snap_d;
    end
  end

endmodule

// File: tb/tb_rtc_access_sequencer.sv
// tb_rtc_access_sequencer: directed scenarios followed by a random phase; every cycle
// the DUT outputs are compared against a transaction-level model of the sequencer.
// Three channels are used so that wr_ch = 3 is representable as an out-of-range channel.
module tb_rtc_access_sequencer;
  localparam int NCH = 3;
  localparam int NR  = 3;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int DIV = 10;
  localparam int TO  = 16;
  localparam int ACH = 1;
  localparam int CW  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_req = 1'b0, init_busy = 1'b0, wr_done = 1'b0, rd_done = 1'b0;
  logic [CW-1:0]    wr_ch = '0;
  logic [NR*DW-1:0] wr_data = '0, rd_data = '0;
  logic             wr_start, rd_start, alarm_on, busy, wr_ack, wr_err, rd_valid, timeout_err;
  logic [NR*AW-1:0] addr_bus;
  logic [NR*DW-1:0] data_bus, snapshot;
  logic [CW-1:0]    cur_ch, rd_ch;

  int tests = 0, fails = 0, cyc = 0;

  always #5 clk = ~clk;

  rtc_access_sequencer #(
    .NUM_CH(NCH), .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(8'h21),
    .CH_STRIDE(8'h20), .ALARM_CH(ACH), .REFRESH_DIV(DIV), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_ch(wr_ch), .wr_data(wr_data),
    .init_busy(init_busy), .wr_done(wr_done), .rd_done(rd_done), .rd_data(rd_data),
    .wr_start(wr_start), .rd_start(rd_start), .addr_bus(addr_bus), .data_bus(data_bus),
    .cur_ch(cur_ch), .alarm_on(alarm_on), .busy(busy), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_valid(rd_valid), .rd_ch(rd_ch), .snapshot(snapshot), .timeout_err(timeout_err)
  );

  // ---------------- reference model ----------------
  // m_state: 0 idle, 1 write in flight, 2 read in flight
  int               m_state = 0, m_cnt = 0, m_ptr = 0, m_cur = 0, m_rdch = 0, m_wd = 0;
  bit               m_tick = 0, m_has = 0, m_wrap = 0;
  logic [NR*DW-1:0] m_data = '0, m_snap = '0;
  bit               e_wrs = 0, e_rds = 0, e_ack = 0, e_err = 0, e_val = 0;
  bit               e_busy = 0, e_alarm = 0, e_to = 0;

  function automatic logic [NR*AW-1:0] exp_addr(input bit has, input int ch);
    logic [NR*AW-1:0] a;
    a = '0;
    if (has)
      for (int i = 0; i < NR; i++) a[i*AW +: AW] = AW'(('h21 + ch * 'h20 + i) % 256);
    return a;
  endfunction

  // Model advances on the same edge as the DUT, from the same sampled inputs
  always @(posedge clk) begin
    e_wrs = 0; e_rds = 0; e_ack = 0; e_err = 0; e_val = 0;
    if (reset) begin
      m_state = 0; m_cnt = 0; m_tick = 0; m_ptr = 0; m_cur = 0; m_has = 0;
      m_data = '0; m_snap = '0; m_rdch = 0; m_wd = 0; e_to = 0;
    end else begin
      m_wrap = (m_cnt == DIV - 1);
      m_cnt  = (m_cnt + 1) % DIV;
      if (m_state == 0) begin
        if (!init_busy) begin
          if (wr_req) begin
            if (int'(wr_ch) < NCH) begin
              m_cur = int'(wr_ch); m_data = wr_data; m_has = 1; e_wrs = 1; m_state = 1; m_wd = 0;
            end else e_err = 1;
          end else if (m_tick) begin
            m_tick = 0; m_cur = m_ptr; m_has = 1; e_rds = 1; m_state = 2; m_wd = 0;
          end
        end
      end else if (m_state == 1 && wr_done) begin
        e_ack = 1; m_state = 0;
      end else if (m_state == 2 && rd_done) begin
        m_snap = rd_data; m_rdch = m_cur; e_val = 1; m_ptr = (m_ptr + 1) % NCH; m_state = 0;
      end else if (m_state != 0) begin
`ifdef RTC_SEQ_TIMEOUT_EN
        m_wd++;
        if (m_wd == TO) begin
          if (m_state == 2) m_ptr = (m_ptr + 1) % NCH;
          m_state = 0; e_to = 1;
        end
`endif
      end
      if (m_wrap) m_tick = 1;
    end
    e_busy  = (m_state != 0);
    e_alarm = (m_state == 1) && (m_cur == ACH);
  end

  // ---------------- checking and engines ----------------
  int wr_cd = 0, rd_cd = 0, wr_dly = 5, rd_dly = 3, rd_done_cyc = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: compare all outputs, then let the engine models answer starts
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk("wr_start", wr_start, e_wrs);
    chk("rd_start", rd_start, e_rds);
    chk("wr_ack", wr_ack, e_ack);
    chk("wr_err", wr_err, e_err);
    chk("rd_valid", rd_valid, e_val);
    chk("busy", busy, e_busy);
    chk("alarm_on", alarm_on, e_alarm);
    chk("cur_ch", cur_ch, m_cur);
    chk("addr_bus", addr_bus, exp_addr(m_has, m_cur));
    chk("data_bus", data_bus, m_data);
    chk("rd_ch", rd_ch, m_rdch);
    chk("snapshot", snapshot, m_snap);
    chk("timeout_err", timeout_err, e_to);
    wr_done = 1'b0;
    rd_done = 1'b0;
    if (reset) begin wr_cd = 0; rd_cd = 0; end
    if (wr_cd > 0) begin wr_cd--; if (wr_cd == 0) wr_done = 1'b1; end
    if (rd_cd > 0) begin
      rd_cd--;
      if (rd_cd == 0) begin rd_done = 1'b1; rd_data = 24'($urandom); rd_done_cyc = cyc; end
    end
    if (e_wrs) wr_cd = wr_dly;   // wr_dly of 0 means the engine never answers
    if (e_rds) rd_cd = rd_dly;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_state != 0 && n < 100) begin step(); n++; end
    chk("idle_bound", n < 100, 1);
  endtask

  // Hold wr_req until the write is launched or rejected, then wait for its ack
  task automatic do_write(input int ch, input logic [NR*DW-1:0] d, input int dly);
    int n;
    n = 0;
    wr_req = 1'b1; wr_ch = CW'(ch); wr_data = d; wr_dly = dly;
    while (!e_wrs && !e_err && n < 100) begin step(); n++; end
    wr_req = 1'b0;
    chk("issue_bound", n < 100, 1);
    if (e_wrs && dly > 0) begin
      n = 0;
      while (!e_ack && n < 100) begin step(); n++; end
      chk("ack_bound", n < 100, 1);
    end
  endtask

  initial begin
    int last, nst, n;
    // reset state
    repeat (3) step();
    reset = 1'b0;

    // ch0 write, engine answers 5 cycles after wr_start
    do_write(0, 24'h123456, 5);
    // ch1 write raises alarm_on for the whole wait
    do_write(1, 24'h0a0b0c, 4);

    // idle refresh: read engine answers in 3 cycles; starts every DIV cycles
    rd_dly = 3; last = 0; nst = 0;
    repeat (50) begin
      step();
      if (rd_start === 1'b1) begin
        if (nst >= 2) chk("rd_period", cyc - last, DIV);
        last = cyc; nst++;
      end
    end
    chk("rd_count", nst >= 4, 1);

    // write request raised while a read is in flight
    n = 0;
    while (m_state != 2 && n < 100) begin step(); n++; end
    chk("rd_wait_bound", n < 100, 1);
    wr_req = 1'b1; wr_ch = 2'd2; wr_data = 24'hc0ffee; wr_dly = 2;
    n = 0;
    while (!(wr_start === 1'b1) && !e_wrs && n < 100) begin step(); n++; end
    wr_req = 1'b0;
    chk("wr_after_rd", cyc - rd_done_cyc, 2);
    n = 0;
    while (!e_ack && n < 100) begin step(); n++; end

    // out-of-range channel is rejected
    do_write(3, 24'hdeadbe, 2);
    repeat (3) step();

    // init_busy blocks both writes and pending refresh
    wait_idle();
    init_busy = 1'b1; wr_req = 1'b1; wr_ch = 2'd0; wr_data = 24'h5a5a5a; wr_dly = 3;
    nst = 0;
    repeat (25) begin step(); if (rd_start === 1'b1 || wr_start === 1'b1) nst++; end
    chk("init_busy_starts", nst, 0);
    init_busy = 1'b0;
    n = 0;
    while (!e_wrs && n < 100) begin step(); n++; end
    wr_req = 1'b0;
    n = 0;
    while (!e_ack && n < 100) begin step(); n++; end

    // reset in the middle of a write abandons it
    wait_idle();
    wr_req = 1'b1; wr_ch = 2'd1; wr_data = 24'h777777; wr_dly = 0;
    n = 0;
    while (!e_wrs && n < 100) begin step(); n++; end
    wr_req = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("busy_after_reset", busy, 0);
    repeat (5) step();

`ifdef RTC_SEQ_TIMEOUT_EN
    // engine never answers: watchdog returns to IDLE and flags
    wait_idle();
    wr_req = 1'b1; wr_ch = 2'd0; wr_data = 24'h010203; wr_dly = 0;
    n = 0;
    while (!e_wrs && n < 100) begin step(); n++; end
    wr_req = 1'b0;
    repeat (20) step();
    chk("timeout_flag", timeout_err, 1);
`endif

    // random phase, including stray completions and occasional reset
    repeat (400) begin
      wr_req    = ($urandom_range(0, 7) == 0);
      wr_ch     = CW'($urandom_range(0, 3));
      wr_data   = 24'($urandom);
      init_busy = ($urandom_range(0, 15) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      wr_dly    = $urandom_range(1, 6);
      rd_dly    = $urandom_range(1, 6);
      step();
      if (wr_cd == 0 && m_state != 1 && $urandom_range(0, 9) == 0) wr_done = 1'b1;
      if (rd_cd == 0 && m_state != 2 && $urandom_range(0, 9) == 0) rd_done = 1'b1;
    end
    reset = 1'b0; wr_req = 1'b0; init_busy = 1'b0;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
